// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between EX and WB. Latches the EX
//            result, issues exactly one SRAM-like data request per load/store
//            (req / addr_ok handshake) and holds it until accepted. Builds the
//            access size, byte strobes and lane-replicated write data for
//            sw/sb/sh/swl/swr, and forwards byte offset, load type and rt so
//            WB can merge data_rdata when data_data_ok arrives.
// Ports    : clk, resetn (async, active-low)
//            EX side  : EX_to_MEM_valid, *_EX payload, MEM_allowin
//            WB side  : WB_allowin, MEM_to_WB_valid, *_MEM payload,
//                       Byte_MEM, mem_access_MEM
//            Bus side : data_req, data_wr, data_size, data_addr, data_wstrb,
//                       data_wdata, data_addr_ok
// Options  : MEM_ALIGN_CHECK_EN - when defined, misaligned lw/sw/lh/lhu/sh
//            suppress the bus request, clear rf_wen_MEM and raise the extra
//            output addr_err_MEM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  // EX side
  input  logic        EX_to_MEM_valid,
  input  logic        WB_allowin,
  input  logic [31:0] PC_EX,
  input  logic [31:0] Instruction_EX,
  input  logic [31:0] alu_result_EX,
  input  logic [31:0] ReadData2_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic [2:0]  StoreType_EX,
  input  logic [3:0]  MemtoReg_EX,
  input  logic [3:0]  rf_wen_EX,
  input  logic [4:0]  rf_waddr_EX,
  // pipeline handshake
  output logic        MEM_allowin,
  output logic        MEM_to_WB_valid,
  // WB payload
  output logic [31:0] PC_MEM,
  output logic [31:0] Instruction_MEM,
  output logic [31:0] ReadData2_MEM,
  output logic [31:0] rf_wdata_temp_MEM,
  output logic [1:0]  Byte_MEM,
  output logic        MemRead_MEM,
  output logic [3:0]  MemtoReg_MEM,
  output logic [3:0]  rf_wen_MEM,
  output logic [4:0]  rf_waddr_MEM,
  output logic        mem_access_MEM,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        addr_err_MEM,
`endif
  // data bus
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok
);

  // Store type encodings
  localparam logic [2:0] ST_SW  = 3'b000;
  localparam logic [2:0] ST_SB  = 3'b001;
  localparam logic [2:0] ST_SH  = 3'b010;
  localparam logic [2:0] ST_SWL = 3'b011;
  localparam logic [2:0] ST_SWR = 3'b100;

  // Load type encodings (MemtoReg)
  localparam logic [3:0] LD_LW  = 4'b0001;
  localparam logic [3:0] LD_LB  = 4'b0100;
  localparam logic [3:0] LD_LBU = 4'b0101;
  localparam logic [3:0] LD_LH  = 4'b0110;
  localparam logic [3:0] LD_LHU = 4'b0111;
  localparam logic [3:0] LD_LWL = 4'b1000;
  localparam logic [3:0] LD_LWR = 4'b1001;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Request tracking: SENT means the bus already accepted this
  // instruction's request but WB has not taken the instruction yet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SENT = 1'b1
  } req_state_t;

  req_state_t  req_state;
  logic        MEM_valid;
  logic        MemWrite_MEM;
  logic [2:0]  StoreType_MEM;
  logic        need_mem;
  logic        req_sent;
  logic        MEM_ready_go;
  logic [1:0]  off;

  // --------------------------------------------------------------------------
  // Optional alignment check, evaluated on the EX fields so the result is
  // registered alongside the rest of the payload.
  // --------------------------------------------------------------------------
`ifdef MEM_ALIGN_CHECK_EN
  logic        mis_EX;
  logic        word_acc_EX;
  logic        half_acc_EX;

  always_comb begin
    word_acc_EX = (MemRead_EX  && (MemtoReg_EX  == LD_LW)) ||
                  (MemWrite_EX && (StoreType_EX == ST_SW));
    half_acc_EX = (MemRead_EX  && ((MemtoReg_EX == LD_LH) || (MemtoReg_EX == LD_LHU))) ||
                  (MemWrite_EX && (StoreType_EX == ST_SH));
    mis_EX      = (word_acc_EX && (alu_result_EX[1:0] != 2'b00)) ||
                  (half_acc_EX && alu_result_EX[0]);
  end
`endif

  // --------------------------------------------------------------------------
  // Stage registers and request state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MEM_valid         <= 1'b0;
      req_state         <= IDLE;
      PC_MEM            <= 32'd0;
      Instruction_MEM   <= 32'd0;
      ReadData2_MEM     <= 32'd0;
      rf_wdata_temp_MEM <= 32'd0;
      MemRead_MEM       <= 1'b0;
      MemWrite_MEM      <= 1'b0;
      StoreType_MEM     <= 3'd0;
      MemtoReg_MEM      <= 4'd0;
      rf_wen_MEM        <= 4'd0;
      rf_waddr_MEM      <= 5'd0;
`ifdef MEM_ALIGN_CHECK_EN
      addr_err_MEM      <= 1'b0;
`endif
    end else begin
      if (MEM_allowin) begin
        MEM_valid <= EX_to_MEM_valid;
      end

      if (EX_to_MEM_valid && MEM_allowin) begin
        PC_MEM            <= PC_EX;
        Instruction_MEM   <= Instruction_EX;
        ReadData2_MEM     <= ReadData2_EX;
        rf_wdata_temp_MEM <= alu_result_EX;
        MemRead_MEM       <= MemRead_EX;
        MemWrite_MEM      <= MemWrite_EX;
        StoreType_MEM     <= StoreType_EX;
        MemtoReg_MEM      <= MemtoReg_EX;
        rf_waddr_MEM      <= rf_waddr_EX;
`ifdef MEM_ALIGN_CHECK_EN
        rf_wen_MEM        <= mis_EX ? 4'b0000 : rf_wen_EX;
        addr_err_MEM      <= mis_EX;
`else
        rf_wen_MEM        <= rf_wen_EX;
`endif
      end

      // Leaving MEM always returns to IDLE; the two conditions are disjoint
      // because SENT is only entered while WB is refusing.
      if (MEM_to_WB_valid && WB_allowin) begin
        req_state <= IDLE;
      end else if (data_req && data_addr_ok && !WB_allowin) begin
        req_state <= SENT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake logic
  // --------------------------------------------------------------------------
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    need_mem = MEM_valid && (MemRead_MEM || MemWrite_MEM) && !addr_err_MEM;
`else
    need_mem = MEM_valid && (MemRead_MEM || MemWrite_MEM);
`endif
    req_sent        = (req_state == SENT);
    data_req        = need_mem && !req_sent;
    // A request accepted this cycle lets the instruction go straight to WB.
    MEM_ready_go    = !need_mem || req_sent || data_addr_ok;
    MEM_to_WB_valid = MEM_valid && MEM_ready_go;
    MEM_allowin     = !MEM_valid || (MEM_ready_go && WB_allowin);
  end

  assign mem_access_MEM = need_mem;
  assign off            = rf_wdata_temp_MEM[1:0];
  assign Byte_MEM       = off;
  assign data_wr        = MemWrite_MEM;

  // --------------------------------------------------------------------------
  // Bus request fields. All derive from registered payload only, so they
  // stay stable while a request waits for data_addr_ok.
  // --------------------------------------------------------------------------
  always_comb begin
    data_addr  = rf_wdata_temp_MEM;
    data_size  = SZ_WORD;
    data_wstrb = 4'b0000;
    data_wdata = 32'd0;

    if (MemWrite_MEM) begin
      unique case (StoreType_MEM)
        ST_SW: begin
          data_wstrb = 4'b1111;
          data_wdata = ReadData2_MEM;
        end
        ST_SB: begin
          data_size  = SZ_BYTE;
          data_wstrb = 4'b0001 << off;
          data_wdata = {4{ReadData2_MEM[7:0]}};
        end
        ST_SH: begin
          data_size  = SZ_HALF;
          data_wstrb = off[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{ReadData2_MEM[15:0]}};
        end
        ST_SWL: begin
          // Most-significant bytes of rt go into the low lanes up to 'off'.
          data_addr = {rf_wdata_temp_MEM[31:2], 2'b00};
          unique case (off)
            2'd0: begin
              data_wstrb = 4'b0001;
              data_wdata = {24'd0, ReadData2_MEM[31:24]};
            end
            2'd1: begin
              data_wstrb = 4'b0011;
              data_wdata = {16'd0, ReadData2_MEM[31:16]};
            end
            2'd2: begin
              data_wstrb = 4'b0111;
              data_wdata = {8'd0, ReadData2_MEM[31:8]};
            end
            default: begin
              data_wstrb = 4'b1111;
              data_wdata = ReadData2_MEM;
            end
          endcase
        end
        ST_SWR: begin
          // Least-significant bytes of rt go into the lanes from 'off' up.
          data_addr = {rf_wdata_temp_MEM[31:2], 2'b00};
          unique case (off)
            2'd0: begin
              data_wstrb = 4'b1111;
              data_wdata = ReadData2_MEM;
            end
            2'd1: begin
              data_wstrb = 4'b1110;
              data_wdata = {ReadData2_MEM[23:0], 8'd0};
            end
            2'd2: begin
              data_wstrb = 4'b1100;
              data_wdata = {ReadData2_MEM[15:0], 16'd0};
            end
            default: begin
              data_wstrb = 4'b1000;
              data_wdata = {ReadData2_MEM[7:0], 24'd0};
            end
          endcase
        end
        default: begin
          data_wstrb = 4'b0000;
        end
      endcase
    end else if (MemRead_MEM) begin
      unique case (MemtoReg_MEM)
        LD_LB, LD_LBU: data_size = SZ_BYTE;
        LD_LH, LD_LHU: data_size = SZ_HALF;
        LD_LWL, LD_LWR: begin
          data_addr = {rf_wdata_temp_MEM[31:2], 2'b00};
        end
        default: data_size = SZ_WORD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Directed scenarios followed by
//            randomized traffic, all compared against a transaction-level
//            model (queue of instructions in flight plus per-instruction
//            request count; bus fields from plain arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        EX_to_MEM_valid;
  logic        WB_allowin;
  logic [31:0] PC_EX;
  logic [31:0] Instruction_EX;
  logic [31:0] alu_result_EX;
  logic [31:0] ReadData2_EX;
  logic        MemRead_EX;
  logic        MemWrite_EX;
  logic [2:0]  StoreType_EX;
  logic [3:0]  MemtoReg_EX;
  logic [3:0]  rf_wen_EX;
  logic [4:0]  rf_waddr_EX;
  logic        MEM_allowin;
  logic        MEM_to_WB_valid;
  logic [31:0] PC_MEM;
  logic [31:0] Instruction_MEM;
  logic [31:0] ReadData2_MEM;
  logic [31:0] rf_wdata_temp_MEM;
  logic [1:0]  Byte_MEM;
  logic        MemRead_MEM;
  logic [3:0]  MemtoReg_MEM;
  logic [3:0]  rf_wen_MEM;
  logic [4:0]  rf_waddr_MEM;
  logic        mem_access_MEM;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_err_MEM;
`endif
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .WB_allowin        (WB_allowin),
    .PC_EX             (PC_EX),
    .Instruction_EX    (Instruction_EX),
    .alu_result_EX     (alu_result_EX),
    .ReadData2_EX      (ReadData2_EX),
    .MemRead_EX        (MemRead_EX),
    .MemWrite_EX       (MemWrite_EX),
    .StoreType_EX      (StoreType_EX),
    .MemtoReg_EX       (MemtoReg_EX),
    .rf_wen_EX         (rf_wen_EX),
    .rf_waddr_EX       (rf_waddr_EX),
    .MEM_allowin       (MEM_allowin),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .PC_MEM            (PC_MEM),
    .Instruction_MEM   (Instruction_MEM),
    .ReadData2_MEM     (ReadData2_MEM),
    .rf_wdata_temp_MEM (rf_wdata_temp_MEM),
    .Byte_MEM          (Byte_MEM),
    .MemRead_MEM       (MemRead_MEM),
    .MemtoReg_MEM      (MemtoReg_MEM),
    .rf_wen_MEM        (rf_wen_MEM),
    .rf_waddr_MEM      (rf_waddr_MEM),
    .mem_access_MEM    (mem_access_MEM),
`ifdef MEM_ALIGN_CHECK_EN
    .addr_err_MEM      (addr_err_MEM),
`endif
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wstrb        (data_wstrb),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] rt;
    logic        rd;
    logic        wr;
    logic [2:0]  st;
    logic [3:0]  mtr;
    logic [3:0]  wen;
    logic [4:0]  waddr;
  } instr_t;

  instr_t q[$];
  int     head_reqs = 0;

  function automatic logic misaligned(input instr_t t);
`ifdef MEM_ALIGN_CHECK_EN
    logic word_acc, half_acc;
    word_acc = (t.rd && t.mtr == 4'd1) || (t.wr && t.st == 3'd0);
    half_acc = (t.rd && (t.mtr == 4'd6 || t.mtr == 4'd7)) || (t.wr && t.st == 3'd2);
    return (word_acc && (t.alu % 4 != 0)) || (half_acc && (t.alu % 2 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic needs_bus(input instr_t t);
    return (t.rd || t.wr) && !misaligned(t);
  endfunction

  function automatic logic [31:0] exp_addr(input instr_t t);
    if ((t.rd && t.mtr >= 4'd8) || (t.wr && t.st >= 3'd3))
      return t.alu - (t.alu % 4);
    return t.alu;
  endfunction

  function automatic logic [1:0] exp_size(input instr_t t);
    if (t.wr) return (t.st == 3'd1) ? 2'd0 : (t.st == 3'd2) ? 2'd1 : 2'd2;
    if (t.mtr == 4'd4 || t.mtr == 4'd5) return 2'd0;
    if (t.mtr == 4'd6 || t.mtr == 4'd7) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] exp_strb(input instr_t t);
    int o;
    int s;
    o = int'(t.alu % 4);
    if (!t.wr) return 4'd0;
    case (t.st)
      3'd0:    s = 15;
      3'd1:    s = 1 << o;
      3'd2:    s = (o >= 2) ? 12 : 3;
      3'd3:    s = (1 << (o + 1)) - 1;
      3'd4:    s = (15 << o) % 16;
      default: s = 0;
    endcase
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input instr_t t);
    int o;
    o = int'(t.alu % 4);
    case (t.st)
      3'd0:    return t.rt;
      3'd1:    return (t.rt % 256) * 32'h01010101;
      3'd2:    return (t.rt % 65536) * 32'h00010001;
      3'd3:    return t.rt >> (8 * (3 - o));
      3'd4:    return t.rt << (8 * o);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                        input logic rd, input logic wr, input logic [2:0] st,
                        input logic [3:0] mtr);
    EX_to_MEM_valid = v;
    PC_EX           = $urandom;
    Instruction_EX  = $urandom;
    alu_result_EX   = alu;
    ReadData2_EX    = rt;
    MemRead_EX      = rd;
    MemWrite_EX     = wr;
    StoreType_EX    = st;
    MemtoReg_EX     = mtr;
    rf_wen_EX       = 4'($urandom_range(0, 15));
    rf_waddr_EX     = 5'($urandom_range(0, 31));
  endtask

  task automatic rand_ex();
    int    kind;
    logic [3:0] ld_types [7];
    ld_types = '{4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    kind = $urandom_range(0, 2);
    case (kind)
      0:       set_ex($urandom_range(0, 9) < 7, $urandom, $urandom, 1'b0, 1'b0, 3'd0, 4'd0);
      1:       set_ex($urandom_range(0, 9) < 7, $urandom, $urandom, 1'b1, 1'b0, 3'd0,
                      ld_types[$urandom_range(0, 6)]);
      default: set_ex($urandom_range(0, 9) < 7, $urandom, $urandom, 1'b0, 1'b1,
                      3'($urandom_range(0, 4)), 4'd0);
    endcase
  endtask

  // One clock cycle: inputs already driven (posedge+1). Checks combinational
  // outputs against the model, then advances the model across the edge.
  task automatic cycle();
    logic   has, hneed, e_req, e_go, e_v2wb, e_allow, leave, accept, acc;
    instr_t h;
    instr_t nx;
    #2;
    has = (q.size() != 0);
    if (has) h = q[0];
    hneed   = has && needs_bus(h);
    e_req   = hneed && (head_reqs == 0);
    e_go    = !hneed || (head_reqs > 0) || data_addr_ok;
    e_v2wb  = has && e_go;
    e_allow = !has || (e_go && WB_allowin);
    leave   = e_v2wb && WB_allowin;
    accept  = EX_to_MEM_valid && e_allow;
    acc     = e_req && data_addr_ok;

    check("data_req", {31'd0, data_req}, {31'd0, e_req});
    check("to_wb_valid", {31'd0, MEM_to_WB_valid}, {31'd0, e_v2wb});
    check("allowin", {31'd0, MEM_allowin}, {31'd0, e_allow});
    if (has) check("mem_access", {31'd0, mem_access_MEM}, {31'd0, hneed});
    if (e_req) begin
      check("data_addr", data_addr, exp_addr(h));
      check("data_size", {30'd0, data_size}, {30'd0, exp_size(h)});
      check("data_wr", {31'd0, data_wr}, {31'd0, h.wr});
      check("data_wstrb", {28'd0, data_wstrb}, {28'd0, exp_strb(h)});
      if (h.wr) check("data_wdata", data_wdata, exp_wdata(h));
    end
    if (leave) begin
      check("pc", PC_MEM, h.pc);
      check("instr", Instruction_MEM, h.ins);
      check("alu", rf_wdata_temp_MEM, h.alu);
      check("rt", ReadData2_MEM, h.rt);
      check("byte", {30'd0, Byte_MEM}, h.alu % 4);
      check("memread", {31'd0, MemRead_MEM}, {31'd0, h.rd});
      check("memtoreg", {28'd0, MemtoReg_MEM}, {28'd0, h.mtr});
      check("rf_wen", {28'd0, rf_wen_MEM}, misaligned(h) ? 32'd0 : {28'd0, h.wen});
      check("rf_waddr", {27'd0, rf_waddr_MEM}, {27'd0, h.waddr});
`ifdef MEM_ALIGN_CHECK_EN
      check("addr_err", {31'd0, addr_err_MEM}, {31'd0, misaligned(h)});
`endif
      check("req_count", head_reqs + (acc ? 1 : 0), hneed ? 32'd1 : 32'd0);
    end
    nx.pc = PC_EX; nx.ins = Instruction_EX; nx.alu = alu_result_EX; nx.rt = ReadData2_EX;
    nx.rd = MemRead_EX; nx.wr = MemWrite_EX; nx.st = StoreType_EX; nx.mtr = MemtoReg_EX;
    nx.wen = rf_wen_EX; nx.waddr = rf_waddr_EX;

    @(posedge clk);
    #1;
    if (leave) begin
      void'(q.pop_front());
      head_reqs = 0;
    end else if (acc) begin
      head_reqs++;
    end
    if (accept) q.push_back(nx);
  endtask

  task automatic bus(input logic ok, input logic wb);
    data_addr_ok = ok;
    WB_allowin   = wb;
  endtask

  initial begin
    resetn = 1'b1;
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    bus(1'b0, 1'b0);
    #1 resetn = 1'b0;
    #1;
    // Reset state
    check("rst_allowin", {31'd0, MEM_allowin}, 32'd1);
    check("rst_to_wb", {31'd0, MEM_to_WB_valid}, 32'd0);
    check("rst_req", {31'd0, data_req}, 32'd0);
    check("rst_pc", PC_MEM, 32'd0);
    check("rst_alu", rf_wdata_temp_MEM, 32'd0);
    check("rst_wen", {28'd0, rf_wen_MEM}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // ALU op, straight through
    set_ex(1'b1, 32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 3'd0, 4'd0); bus(1'b0, 1'b1); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0); cycle();
    check("alu_result", rf_wdata_temp_MEM, 32'hCAFE_0001);

    // lw at 0x1000, addr_ok three cycles late
    set_ex(1'b1, 32'h1000, 32'h0, 1'b1, 1'b0, 3'd0, 4'd1); bus(1'b0, 1'b1); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    for (int i = 0; i < 3; i++) cycle();
    bus(1'b1, 1'b1); cycle();

    // sb at 0x1003
    set_ex(1'b1, 32'h1003, 32'h12345678, 1'b0, 1'b1, 3'd1, 4'd0); bus(1'b0, 1'b1); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0); cycle();
    check("sb_strb", {28'd0, data_wstrb}, 32'h8);
    check("sb_wdata", data_wdata, 32'h78787878);
    bus(1'b1, 1'b1); cycle();

    // swl 0x2001 then swr 0x2002
    set_ex(1'b1, 32'h2001, 32'hAABBCCDD, 1'b0, 1'b1, 3'd3, 4'd0); bus(1'b0, 1'b1); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0); cycle();
    check("swl_addr", data_addr, 32'h2000);
    check("swl_wdata", data_wdata, 32'h0000AABB);
    bus(1'b1, 1'b1);
    set_ex(1'b1, 32'h2002, 32'hAABBCCDD, 1'b0, 1'b1, 3'd4, 4'd0); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0); bus(1'b0, 1'b1); cycle();
    check("swr_strb", {28'd0, data_wstrb}, 32'hC);
    check("swr_wdata", data_wdata, 32'hCCDD0000);
    bus(1'b1, 1'b1); cycle();

    // addr_ok while WB blocked: one request only
    set_ex(1'b1, 32'h3000, 32'h55, 1'b0, 1'b1, 3'd0, 4'd0); bus(1'b0, 1'b1); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    bus(1'b1, 1'b0); cycle();
    bus(1'b1, 1'b0); cycle();
    bus(1'b0, 1'b1); cycle();

    // Reset mid-request
    set_ex(1'b1, 32'h1000, 32'h0, 1'b1, 1'b0, 3'd0, 4'd1); bus(1'b0, 1'b1); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0);
    #2;
    check("pre_rst_req", {31'd0, data_req}, 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst_req", {31'd0, data_req}, 32'd0);
    check("midrst_to_wb", {31'd0, MEM_to_WB_valid}, 32'd0);
    check("midrst_pc", PC_MEM, 32'd0);
    check("midrst_addr", data_addr, 32'd0);
    check("midrst_allowin", {31'd0, MEM_allowin}, 32'd1);
    q.delete();
    head_reqs = 0;
    @(posedge clk);
    #1 resetn = 1'b1;

`ifdef MEM_ALIGN_CHECK_EN
    set_ex(1'b1, 32'h1002, 32'h0, 1'b1, 1'b0, 3'd0, 4'd1); bus(1'b0, 1'b0); cycle();
    set_ex(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0); cycle();
    check("mis_err", {31'd0, addr_err_MEM}, 32'd1);
    check("mis_wen", {28'd0, rf_wen_MEM}, 32'd0);
    bus(1'b0, 1'b1); cycle();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_ex();
      bus($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
